// File: rtl/traffic_phase_controller_if.sv
// Signal bundle between the intersection controller and its lamp/countdown consumers.
// The master modport drives the timing inputs; the slave modport is the controller itself.
interface traffic_phase_controller_if #(
    parameter int unsigned N_DIR      = 2,
    parameter int unsigned TIME_W     = 6,
    parameter int unsigned TIMELEFT_W = 7
);
    localparam int unsigned DIR_W = $clog2(N_DIR);

    logic                          ce;
    logic [N_DIR*TIME_W-1:0]       green_time;
    logic [N_DIR-1:0]              ped_req;
    logic                          flash;
    logic [3*N_DIR-1:0]            lights;
    logic [DIR_W-1:0]              active_dir;
    logic [N_DIR*TIMELEFT_W-1:0]   time_left;

    modport master (
        output ce, green_time, ped_req, flash,
        input  lights, active_dir, time_left
    );

    modport slave (
        input  ce, green_time, ped_req, flash,
        output lights, active_dir, time_left
    );
endinterface

// File: rtl/traffic_phase_controller.sv
// N-direction intersection phase controller: green/yellow/all-red rotation, pedestrian early
// termination, night flash mode and registered per-direction countdowns.
module traffic_phase_controller #(
    parameter int unsigned N_DIR       = 2,
    parameter int unsigned TIME_W      = 6,
    parameter int unsigned TIMELEFT_W  = 7,
    parameter int unsigned YELLOW_TIME = 3,
    parameter int unsigned ALLRED_TIME = 1,
    parameter int unsigned MIN_GREEN   = 4
) (
    input logic                       clk,
    input logic                       rst,
    traffic_phase_controller_if.slave bus
);
    localparam int unsigned DIR_W  = $clog2(N_DIR);
    localparam int unsigned Y_W    = $clog2(YELLOW_TIME + 1);
    localparam int unsigned A_W    = $clog2(ALLRED_TIME + 1);
    localparam int unsigned YA_W   = (Y_W > A_W) ? Y_W : A_W;
    localparam int unsigned CNT_W  = (TIME_W > YA_W) ? TIME_W : YA_W;
    localparam int unsigned EL_W   = (MIN_GREEN > 0) ? $clog2(MIN_GREEN + 1) : 1;
    localparam int unsigned SUM_W  = ((CNT_W > TIMELEFT_W) ? CNT_W : TIMELEFT_W) + 2;

    localparam logic [CNT_W-1:0] YELLOW_CNT = CNT_W'(YELLOW_TIME);
    localparam logic [CNT_W-1:0] ALLRED_CNT = CNT_W'(ALLRED_TIME);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [DIR_W-1:0] DIR_LAST   = DIR_W'(N_DIR - 1);
    localparam logic [EL_W-1:0]  EL_MAX     = '1;
    localparam logic [SUM_W-1:0] TL_SAT     = SUM_W'(2 ** TIMELEFT_W - 2);

    typedef enum logic [1:0] {StClear, StGreen, StYellow, StFlash} state_e;

    state_e                      state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [DIR_W-1:0]            dir_q, dir_d;
    logic [N_DIR-1:0]            pend_q, pend_d;
    logic [EL_W-1:0]             elapsed_q, elapsed_d;
    logic                        blink_q, blink_d;
    logic [3*N_DIR-1:0]          lights_q, lights_d;
    logic [N_DIR*TIMELEFT_W-1:0] tl_q, tl_d;

    function automatic logic [DIR_W-1:0] next_dir(input logic [DIR_W-1:0] d);
        return (d == DIR_LAST) ? '0 : d + DIR_W'(1);
    endfunction

    function automatic logic [3*N_DIR-1:0] lamp_calc(input state_e st, input logic [DIR_W-1:0] dir,
                                                     input logic blink);
        logic [3*N_DIR-1:0] res;
        res = '0;
        for (int d = 0; d < N_DIR; d++) begin
            if (st == StFlash)                         res[3*d +: 3] = {1'b0, blink, 1'b0};
            else if (DIR_W'(d) == dir && st == StGreen)  res[3*d +: 3] = 3'b001;
            else if (DIR_W'(d) == dir && st == StYellow) res[3*d +: 3] = 3'b010;
            else                                       res[3*d +: 3] = 3'b100;
        end
        return res;
    endfunction

    // Unscheduled directions read all-ones; scheduled values saturate one below that.
    function automatic logic [N_DIR*TIMELEFT_W-1:0] tl_calc(input state_e st,
                                                            input logic [CNT_W-1:0] cnt,
                                                            input logic [DIR_W-1:0] dir);
        logic [N_DIR*TIMELEFT_W-1:0] res;
        logic [SUM_W-1:0]            sum;
        logic [DIR_W-1:0]            nd;
        logic                        sched;
        res = '1;
        nd  = next_dir(dir);
        for (int d = 0; d < N_DIR; d++) begin
            sched = 1'b0;
            sum   = '0;
            if ((st == StGreen || st == StYellow) && DIR_W'(d) == dir) begin
                sched = 1'b1;
                sum   = SUM_W'(cnt);
            end else if (st != StFlash && DIR_W'(d) == nd) begin
                sched = 1'b1;
                if (st == StGreen)
                    sum = SUM_W'(cnt) + SUM_W'(YELLOW_TIME) + SUM_W'(ALLRED_TIME);
                else if (st == StYellow)
                    sum = SUM_W'(cnt) + SUM_W'(ALLRED_TIME);
                else
                    sum = SUM_W'(cnt);
            end
            if (sched)
                res[d*TIMELEFT_W +: TIMELEFT_W] = (sum > TL_SAT) ? TL_SAT[TIMELEFT_W-1:0]
                                                                 : sum[TIMELEFT_W-1:0];
        end
        return res;
    endfunction

    logic [DIR_W-1:0]  nd;
    logic [N_DIR-1:0]  green_mask;
    logic [TIME_W-1:0] gt;
    logic              others_pending;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dir_d     = dir_q;
        elapsed_d = elapsed_q;
        blink_d   = blink_q;
        nd        = next_dir(dir_q);
        gt        = bus.green_time[nd*TIME_W +: TIME_W];
        green_mask     = (state_q == StGreen) ? (N_DIR'(1) << dir_q) : '0;
        others_pending = |(pend_q & ~(N_DIR'(1) << dir_q));
        // Requests latch on every clock edge, independent of ce.
        pend_d    = pend_q | (bus.ped_req & ~green_mask);

        if (bus.ce) begin
            unique case (state_q)
                StClear: begin
                    if (cnt_q == CNT_ONE) begin
                        if (bus.flash) begin
                            state_d = StFlash;
                            blink_d = 1'b1;
                        end else begin
                            state_d   = StGreen;
                            dir_d     = nd;
                            pend_d    = pend_d & ~(N_DIR'(1) << nd);
                            elapsed_d = '0;
                            cnt_d     = (gt == '0) ? CNT_ONE : CNT_W'(gt);
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                StGreen: begin
                    if (elapsed_q != EL_MAX) elapsed_d = elapsed_q + EL_W'(1);
                    if (cnt_q == CNT_ONE ||
                        ((32'(elapsed_q) + 32'd1 >= MIN_GREEN) && others_pending)) begin
                        state_d = StYellow;
                        cnt_d   = YELLOW_CNT;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                StYellow: begin
                    if (cnt_q == CNT_ONE) begin
                        state_d = StClear;
                        cnt_d   = ALLRED_CNT;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                StFlash: begin
                    if (!bus.flash) begin
                        state_d = StClear;
                        cnt_d   = ALLRED_CNT;
                    end else begin
                        blink_d = ~blink_q;
                    end
                end
            endcase
        end

        lights_d = lamp_calc(state_d, dir_d, blink_d);
        tl_d     = tl_calc(state_d, cnt_d, dir_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StClear;
            cnt_q     <= ALLRED_CNT;
            dir_q     <= DIR_LAST;
            pend_q    <= '0;
            elapsed_q <= '0;
            blink_q   <= 1'b0;
            lights_q  <= lamp_calc(StClear, DIR_LAST, 1'b0);
            tl_q      <= tl_calc(StClear, ALLRED_CNT, DIR_LAST);
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dir_q     <= dir_d;
            pend_q    <= pend_d;
            elapsed_q <= elapsed_d;
            blink_q   <= blink_d;
            lights_q  <= lights_d;
            tl_q      <= tl_d;
        end
    end

    assign bus.lights     = lights_q;
    assign bus.active_dir = dir_q;
    assign bus.time_left  = tl_q;
endmodule

// File: tb/tb_traffic_phase_controller.sv
// Directed bench for traffic_phase_controller: a 2-direction instance for rotation, reset,
// ce gating, pedestrian cut and flash, plus a 4-direction instance for zero green and saturation.
module tb_traffic_phase_controller;
    logic clk = 1'b0;
    logic rst2, rst4;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    traffic_phase_controller_if #(.N_DIR(2), .TIME_W(6), .TIMELEFT_W(7)) b2 ();
    traffic_phase_controller_if #(.N_DIR(4), .TIME_W(6), .TIMELEFT_W(7)) b4 ();

    traffic_phase_controller #(.N_DIR(2)) dut2 (.clk(clk), .rst(rst2), .bus(b2));
    traffic_phase_controller #(.N_DIR(4), .YELLOW_TIME(64)) dut4 (.clk(clk), .rst(rst4), .bus(b4));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic c2(input string tag, input logic [5:0] l, input logic a,
                      input logic [6:0] t0, input logic [6:0] t1);
        chk({tag, ".lights"}, 32'(b2.lights), 32'(l));
        chk({tag, ".dir"},    32'(b2.active_dir), 32'(a));
        chk({tag, ".tl0"},    32'(b2.time_left[6:0]), 32'(t0));
        chk({tag, ".tl1"},    32'(b2.time_left[13:7]), 32'(t1));
    endtask

    task automatic c4(input string tag, input logic [11:0] l, input logic [1:0] a,
                      input logic [6:0] t0, input logic [6:0] t1);
        chk({tag, ".lights"}, 32'(b4.lights), 32'(l));
        chk({tag, ".dir"},    32'(b4.active_dir), 32'(a));
        chk({tag, ".tl0"},    32'(b4.time_left[6:0]), 32'(t0));
        chk({tag, ".tl1"},    32'(b4.time_left[13:7]), 32'(t1));
    endtask

    task automatic pulse_rst2();
        rst2 = 1'b1;
        #2;
        rst2 = 1'b0;
    endtask

    initial begin
        rst2 = 1'b1;
        rst4 = 1'b1;
        b2.ce = 1'b0;  b2.green_time = {6'd3, 6'd5};  b2.ped_req = '0;  b2.flash = 1'b0;
        b4.ce = 1'b0;  b4.green_time = {6'd0, 6'd0, 6'd0, 6'd63};  b4.ped_req = '0;
        b4.flash = 1'b0;
        #12;
        c2("reset2", 6'b100100, 1'b1, 7'd1, 7'd127);
        c4("reset4", 12'b100100100100, 2'd3, 7'd1, 7'd127);
        rst2 = 1'b0;
        rst4 = 1'b0;

        // Plain rotation, green {5,3}
        b2.ce = 1'b1;
        cyc(1);  c2("g0_t1", 6'b100001, 1'b0, 7'd5, 7'd9);
        cyc(4);  c2("g0_t5", 6'b100001, 1'b0, 7'd1, 7'd5);
        cyc(1);  c2("y0",    6'b100010, 1'b0, 7'd3, 7'd4);
        cyc(3);  c2("ar0",   6'b100100, 1'b0, 7'd127, 7'd1);
        cyc(1);  c2("g1",    6'b001100, 1'b1, 7'd7, 7'd3);

        // Asynchronous reset mid-green, between clock edges
        cyc(1);
        rst2 = 1'b1;
        #2;
        c2("async_rst", 6'b100100, 1'b1, 7'd1, 7'd127);
        rst2 = 1'b0;
        cyc(1);  c2("post_rst_g0", 6'b100001, 1'b0, 7'd5, 7'd9);

        // ce asserted one clock in three
        pulse_rst2();
        b2.ce = 1'b0;
        cyc(2);  c2("ce0_hold", 6'b100100, 1'b1, 7'd1, 7'd127);
        b2.ce = 1'b1;  cyc(1);  b2.ce = 1'b0;
        c2("ce_g0", 6'b100001, 1'b0, 7'd5, 7'd9);
        for (int i = 0; i < 4; i++) begin
            cyc(2);
            b2.ce = 1'b1;  cyc(1);  b2.ce = 1'b0;
        end
        c2("ce_t5", 6'b100001, 1'b0, 7'd1, 7'd5);
        cyc(2);  c2("ce_hold_t5", 6'b100001, 1'b0, 7'd1, 7'd5);
        b2.ce = 1'b1;
        cyc(1);  c2("ce_y0", 6'b100010, 1'b0, 7'd3, 7'd4);

        // Pedestrian request cuts a long green after MIN_GREEN
        b2.green_time = {6'd3, 6'd20};
        pulse_rst2();
        cyc(1);  c2("ped_g0", 6'b100001, 1'b0, 7'd20, 7'd24);
        cyc(1);
        b2.ped_req = 2'b10;
        cyc(1);
        b2.ped_req = 2'b00;
        c2("ped_t3", 6'b100001, 1'b0, 7'd18, 7'd22);
        cyc(1);  c2("ped_t4",  6'b100001, 1'b0, 7'd17, 7'd21);
        cyc(1);  c2("ped_cut", 6'b100010, 1'b0, 7'd3, 7'd4);
        cyc(4);  c2("ped_g1",  6'b001100, 1'b1, 7'd7, 7'd3);
        cyc(7);  c2("ped_g0b", 6'b100001, 1'b0, 7'd20, 7'd24);
        cyc(4);  c2("ped_cleared", 6'b100001, 1'b0, 7'd16, 7'd20);

        // Flash requested during green; yellow and all-red complete first
        b2.green_time = {6'd3, 6'd5};
        pulse_rst2();
        cyc(1);
        b2.flash = 1'b1;
        cyc(5);  c2("fl_y0",   6'b100010, 1'b0, 7'd3, 7'd4);
        cyc(3);  c2("fl_ar",   6'b100100, 1'b0, 7'd127, 7'd1);
        cyc(1);  c2("fl_on1",  6'b010010, 1'b0, 7'd127, 7'd127);
        cyc(1);  c2("fl_off",  6'b000000, 1'b0, 7'd127, 7'd127);
        cyc(1);  c2("fl_on2",  6'b010010, 1'b0, 7'd127, 7'd127);
        b2.flash = 1'b0;
        cyc(1);  c2("fl_exit", 6'b100100, 1'b0, 7'd127, 7'd1);
        cyc(1);  c2("fl_g1",   6'b001100, 1'b1, 7'd7, 7'd3);

        // 4 directions: green 63 on dir0 (countdown saturation), zero green elsewhere
        b4.ce = 1'b1;
        cyc(1);   c4("d4_g0",  12'b100100100001, 2'd0, 7'd63, 7'd126);
        chk("d4_g0.tl2", 32'(b4.time_left[20:14]), 32'd127);
        chk("d4_g0.tl3", 32'(b4.time_left[27:21]), 32'd127);
        cyc(62);  c4("d4_g0_end", 12'b100100100001, 2'd0, 7'd1, 7'd66);
        cyc(1);   c4("d4_y0",  12'b100100100010, 2'd0, 7'd64, 7'd65);
        cyc(64);  c4("d4_ar0", 12'b100100100100, 2'd0, 7'd127, 7'd1);
        cyc(1);   c4("d4_g1",  12'b100100001100, 2'd1, 7'd127, 7'd1);
        chk("d4_g1.tl2", 32'(b4.time_left[20:14]), 32'd66);
        cyc(1);   c4("d4_y1",  12'b100100010100, 2'd1, 7'd127, 7'd64);
        cyc(65);  c4("d4_g2",  12'b100001100100, 2'd2, 7'd127, 7'd127);
        cyc(66);  c4("d4_g3",  12'b001100100100, 2'd3, 7'd66, 7'd127);
        cyc(1);   c4("d4_y3",  12'b010100100100, 2'd3, 7'd65, 7'd127);
        cyc(65);  c4("d4_g0b", 12'b100100100001, 2'd0, 7'd63, 7'd126);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
